// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared sequencer state type, STATUS_RD bit positions and default IOBUS addresses.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } tx_state_t;

   localparam int STAT_FULL   = 0;
   localparam int STAT_EMPTY  = 1;
   localparam int STAT_OVF    = 2;
   localparam int STAT_BUSY   = 3;
   localparam int STAT_CNT_LO = 8;
   localparam int STAT_CNT_HI = 12;

   // Bit of a STATUS_AD write that clears the sticky overflow flag
   localparam int OVF_CLR_BIT = 2;

   // READY cycles tolerated in WAIT_BUSY before the start is treated as missed
   localparam int MISS_LIMIT = 4;

   localparam logic [31:0] DEF_DATA_AD   = 32'h1118_0000;
   localparam logic [31:0] DEF_STATUS_AD = 32'h111C_0000;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output; a push into a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: IOBUS-mapped byte FIFO feeding a UART driver through a START/READY handshake.
// Optional drain interrupt TX_IRQ exists only when UART_TX_IRQ_EN is defined.
module uart_tx_sequencer
   import uart_tx_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] DATA_AD   = DEF_DATA_AD,
   parameter logic [31:0] STATUS_AD = DEF_STATUS_AD
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] STATUS_RD,
   output logic        UART_START,
   output logic [7:0]  UART_DATA,
   input  logic        UART_READY
`ifdef UART_TX_IRQ_EN
   ,
   output logic        TX_IRQ
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   tx_state_t     state;
   tx_state_t     state_next;
   logic [1:0]    miss_cnt;
   logic          push;
   logic          pop;
   logic          clr_ovf;
   logic          ovf;
   logic          full;
   logic          empty;
   logic [7:0]    head;
   logic [CW-1:0] count;
   logic          unused_bits;

   assign push        = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
   assign clr_ovf     = IOBUS_WR && (IOBUS_ADDR == STATUS_AD) && IOBUS_OUT[OVF_CLR_BIT];
   assign pop         = (state == IDLE) && !empty && UART_READY;
   assign unused_bits = ^IOBUS_OUT[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .pop   (pop),
      .din   (IOBUS_OUT[7:0]),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A dropped push sets OVF; setting has priority over a same-cycle clear
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ovf <= 1'b0;
      end else if (push && full && !pop) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

   // UART_DATA only changes on a pop, so it stays stable for the whole frame
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         miss_cnt  <= '0;
         UART_DATA <= 8'h00;
      end else begin
         state <= state_next;
         if (pop) UART_DATA <= head;
         if (state != WAIT_BUSY) begin
            miss_cnt <= '0;
         end else if (UART_READY) begin
            miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      UART_START = 1'b0;
      case (state)
         IDLE: begin
            if (pop) state_next = START;
         end
         START: begin
            UART_START = 1'b1;
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!UART_READY) begin
               state_next = WAIT_DONE;
            end else if (miss_cnt == 2'(MISS_LIMIT - 1)) begin
               state_next = IDLE;
            end
         end
         WAIT_DONE: begin
            if (UART_READY) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      STATUS_RD = '0;
      if (IOBUS_ADDR == STATUS_AD) begin
         STATUS_RD[STAT_FULL]               = full;
         STATUS_RD[STAT_EMPTY]              = empty;
         STATUS_RD[STAT_OVF]                = ovf;
         STATUS_RD[STAT_BUSY]               = (state != IDLE);
         STATUS_RD[STAT_CNT_HI:STAT_CNT_LO] = 5'(count);
      end
   end

`ifdef UART_TX_IRQ_EN
   // Fires once a frame completes with nothing left queued behind it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         TX_IRQ <= 1'b0;
      end else begin
         TX_IRQ <= (state == WAIT_DONE) && UART_READY && empty;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: table vectors, directed handshake sequences and a randomized run
// checked against a queue-based model of the byte stream and FIFO occupancy.
module tb_uart_tx_sequencer;

   localparam int          DEPTH     = 8;
   localparam logic [31:0] DATA_AD   = 32'h1118_0000;
   localparam logic [31:0] STATUS_AD = 32'h111C_0000;

   localparam int OP_IDLE = 0;
   localparam int OP_PUSH = 1;
   localparam int OP_CLR  = 2;
   localparam int OP_BAD  = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] IOBUS_ADDR = '0;
   logic [31:0] IOBUS_OUT = '0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] STATUS_RD;
   logic        UART_START;
   logic [7:0]  UART_DATA;
   logic        UART_READY = 1'b1;
`ifdef UART_TX_IRQ_EN
   logic        TX_IRQ;
`endif

   uart_tx_sequencer #(
      .DEPTH     (DEPTH),
      .DATA_AD   (DATA_AD),
      .STATUS_AD (STATUS_AD)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .STATUS_RD  (STATUS_RD),
      .UART_START (UART_START),
      .UART_DATA  (UART_DATA),
      .UART_READY (UART_READY)
`ifdef UART_TX_IRQ_EN
      ,
      .TX_IRQ     (TX_IRQ)
`endif
   );

   always #5 CLK = ~CLK;

   int         n_checks = 0;
   int         n_errors = 0;

   // Reference model: bytes accepted but not yet started, plus sticky overflow
   logic [7:0] exp_q[$];
   int         occ = 0;
   logic       ovf_m = 1'b0;
   logic [7:0] last_data = 8'h00;
   int         n_starts = 0;
   int         n_irq = 0;

   // UART driver model: drops READY for busy_len cycles after each START (0 = never drops)
   logic       ready_drv = 1'b1;
   logic       prev_ready = 1'b1;
   logic       last_popped = 1'b0;
   int         busy_len = 3;
   int         busy_left = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] probe;
      logic [31:0] exp_status;
   } vec_t;
   vec_t vecs[$];

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s         = '0;
      s[0]      = (occ == DEPTH);
      s[1]      = (occ == 0);
      s[2]      = ovf_m;
      s[12:8]   = 5'(occ);
      return s;
   endfunction

   function automatic void model_clear();
      exp_q.delete();
      occ       = 0;
      ovf_m     = 1'b0;
      last_data = 8'h00;
   endfunction

   task automatic do_reset();
      RST        = 1'b1;
      IOBUS_WR   = 1'b0;
      IOBUS_ADDR = STATUS_AD;
      IOBUS_OUT  = '0;
      UART_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check_output("reset_status", STATUS_RD, 32'h0000_0002);
      check_output("reset_start", 32'(UART_START), 32'h0);
      check_output("reset_data", 32'(UART_DATA), 32'h0);
      RST = 1'b0;
      model_clear();
      ready_drv = 1'b1;
      busy_left = 0;
      n_starts  = 0;
      n_irq     = 0;
   endtask

   // One clock: drive a bus operation, let the edge pass, update the model and compare
   task automatic apply_stimulus(input int op, input logic [7:0] b);
      logic popped;
      int   occ_before;
      IOBUS_WR   = (op != OP_IDLE);
      IOBUS_ADDR = (op == OP_CLR) ? STATUS_AD : (op == OP_BAD) ? (DATA_AD ^ 32'h0000_0100) : DATA_AD;
      IOBUS_OUT  = (op == OP_CLR) ? 32'h0000_0004 : {24'($urandom), b};
      UART_READY = ready_drv;
      prev_ready = ready_drv;
      @(posedge CLK);
      #1;
      popped      = UART_START;
      last_popped = popped;
      occ_before  = occ;
`ifdef UART_TX_IRQ_EN
      if (TX_IRQ) n_irq++;
`endif
      if (popped) begin
         check_output("start_needs_ready", 32'(prev_ready), 32'h1);
         check_output("start_from_empty", 32'(exp_q.size() == 0), 32'h0);
         if (exp_q.size() != 0) begin
            check_output("start_data", 32'(UART_DATA), 32'(exp_q.pop_front()));
            occ--;
         end
         last_data = UART_DATA;
         n_starts++;
         if (busy_len > 0) begin
            ready_drv = 1'b0;
            busy_left = busy_len;
         end
      end else begin
         check_output("data_hold", 32'(UART_DATA), 32'(last_data));
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) ready_drv = 1'b1;
         end
      end
      if (op == OP_PUSH) begin
         if (occ_before < DEPTH || popped) begin
            exp_q.push_back(b);
            occ++;
         end else begin
            ovf_m = 1'b1;
         end
      end else if (op == OP_CLR) begin
         ovf_m = 1'b0;
      end
      IOBUS_WR   = 1'b0;
      IOBUS_ADDR = STATUS_AD;
      #1;
      check_output("status", STATUS_RD & 32'hFFFF_FFF7, model_status());
   endtask

   task automatic run_until_starts(input int target, input int budget, input string name);
      for (int i = 0; i < budget && n_starts < target; i++) apply_stimulus(OP_IDLE, 8'h00);
      check_output(name, 32'(n_starts), 32'(target));
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // ---------------- Table-driven bus/status vectors, READY held low ----------------
      vecs.push_back('{1'b0, STATUS_AD, 32'h0000_0000, STATUS_AD, 32'h0000_0002});
      vecs.push_back('{1'b1, DATA_AD, 32'hFFFF_FF10, STATUS_AD, 32'h0000_0100});
      vecs.push_back('{1'b1, DATA_AD | 32'h0000_0004, 32'h0000_0099, STATUS_AD, 32'h0000_0100});
      vecs.push_back('{1'b0, DATA_AD, 32'h0000_0055, STATUS_AD, 32'h0000_0100});
      vecs.push_back('{1'b1, STATUS_AD, 32'h0000_0004, STATUS_AD, 32'h0000_0100});
      vecs.push_back('{1'b0, STATUS_AD, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{1'b0, STATUS_AD, 32'h0000_0000, DATA_AD, 32'h0000_0000});
      for (int k = 1; k <= 7; k++)
         vecs.push_back('{1'b1, DATA_AD, 32'(k), STATUS_AD, (k == 7) ? 32'h0000_0801 : 32'((k + 1) << 8)});
      vecs.push_back('{1'b1, DATA_AD, 32'h0000_0008, STATUS_AD, 32'h0000_0805});
      vecs.push_back('{1'b1, STATUS_AD, 32'hFFFF_FFFB, STATUS_AD, 32'h0000_0805});
      vecs.push_back('{1'b1, STATUS_AD, 32'h0000_0004, STATUS_AD, 32'h0000_0801});
      vecs.push_back('{1'b1, DATA_AD, 32'h0000_0009, STATUS_AD, 32'h0000_0805});
      vecs.push_back('{1'b1, STATUS_AD, 32'h0000_0004, STATUS_AD, 32'h0000_0801});

      do_reset();
      foreach (vecs[i]) begin
         IOBUS_WR   = vecs[i].wr;
         IOBUS_ADDR = vecs[i].addr;
         IOBUS_OUT  = vecs[i].data;
         UART_READY = 1'b0;
         @(posedge CLK);
         #1;
         IOBUS_WR   = 1'b0;
         IOBUS_ADDR = vecs[i].probe;
         #1;
         check_output($sformatf("vec%0d_status", i), STATUS_RD, vecs[i].exp_status);
         check_output($sformatf("vec%0d_nostart", i), 32'(UART_START), 32'h0);
      end

      // The table left 0x10,0x01..0x07 queued with OVF cleared; drain and check order
      model_clear();
      exp_q.push_back(8'h10);
      for (int k = 1; k <= 7; k++) exp_q.push_back(8'(k));
      occ       = DEPTH;
      ready_drv = 1'b1;
      busy_left = 0;
      busy_len  = 3;
      n_starts  = 0;
      run_until_starts(8, 200, "table_drain_count");

      // ---------------- First-byte latency and missed-start recovery ----------------
      do_reset();
      busy_len = 0;
      apply_stimulus(OP_PUSH, 8'h41);
      check_output("latency_push_edge", 32'(last_popped), 32'h0);
      apply_stimulus(OP_IDLE, 8'h00);
      check_output("latency_start", 32'(last_popped), 32'h1);
      check_output("latency_data", 32'(UART_DATA), 32'h41);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(OP_IDLE, 8'h00);
         check_output("missed_busy", 32'(STATUS_RD[3]), 32'h1);
         check_output("start_one_cycle", 32'(last_popped), 32'h0);
      end
      apply_stimulus(OP_IDLE, 8'h00);
      check_output("missed_back_idle", 32'(STATUS_RD[3]), 32'h0);
      repeat (10) apply_stimulus(OP_IDLE, 8'h00);
      check_output("missed_no_resend", 32'(n_starts), 32'h1);

      // ---------------- Three bytes against a slow UART ----------------
      do_reset();
      ready_drv = 1'b0;
      busy_len  = 10;
      apply_stimulus(OP_PUSH, 8'hC1);
      apply_stimulus(OP_PUSH, 8'hC2);
      apply_stimulus(OP_PUSH, 8'hC3);
      ready_drv = 1'b1;
      run_until_starts(3, 150, "slow_uart_starts");
      repeat (20) apply_stimulus(OP_IDLE, 8'h00);
      check_output("slow_uart_no_extra", 32'(n_starts), 32'h3);
      check_output("slow_uart_empty", 32'(STATUS_RD[1]), 32'h1);

      // ---------------- Push into a full FIFO on the same edge as a pop ----------------
      do_reset();
      ready_drv = 1'b0;
      busy_len  = 2;
      for (int k = 0; k < DEPTH; k++) apply_stimulus(OP_PUSH, 8'(8'hA0 + k));
      check_output("fill_full", 32'(STATUS_RD[0]), 32'h1);
      ready_drv = 1'b1;
      apply_stimulus(OP_PUSH, 8'hA8);
      check_output("coinc_pop", 32'(last_popped), 32'h1);
      check_output("coinc_count", 32'(STATUS_RD[12:8]), 32'(DEPTH));
      check_output("coinc_ovf", 32'(STATUS_RD[2]), 32'h0);
      run_until_starts(DEPTH + 1, 200, "coinc_drain_count");

      // ---------------- Reset while a frame is in WAIT_DONE ----------------
      do_reset();
      ready_drv = 1'b0;
      busy_len  = 10;
      for (int k = 0; k < 6; k++) apply_stimulus(OP_PUSH, 8'(8'h60 + k));
      ready_drv = 1'b1;
      run_until_starts(1, 20, "rst_first_start");
      repeat (3) apply_stimulus(OP_IDLE, 8'h00);
      check_output("rst_pre_busy", 32'(STATUS_RD[3]), 32'h1);
      check_output("rst_pre_count", 32'(STATUS_RD[12:8]), 32'h5);
      #2;
      RST = 1'b1;
      #2;
      check_output("rst_async_status", STATUS_RD, 32'h0000_0002);
      check_output("rst_async_start", 32'(UART_START), 32'h0);
      check_output("rst_async_data", 32'(UART_DATA), 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_clear();
      n_starts = 0;
      repeat (40) apply_stimulus(OP_IDLE, 8'h00);
      check_output("rst_no_start_after", 32'(n_starts), 32'h0);

`ifdef UART_TX_IRQ_EN
      // ---------------- Drain interrupt after two bytes ----------------
      begin
         int irq_at_second;
         do_reset();
         ready_drv = 1'b0;
         busy_len  = 5;
         apply_stimulus(OP_PUSH, 8'h31);
         apply_stimulus(OP_PUSH, 8'h32);
         ready_drv = 1'b1;
         run_until_starts(2, 60, "irq_starts");
         irq_at_second = n_irq;
         repeat (20) apply_stimulus(OP_IDLE, 8'h00);
         check_output("irq_none_before_last", 32'(irq_at_second), 32'h0);
         check_output("irq_single_pulse", 32'(n_irq), 32'h1);
      end
`endif

      // ---------------- Randomized traffic against the model ----------------
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         int r;
         r        = $urandom_range(0, 99);
         busy_len = $urandom_range(0, 12);
         if (r < 55)      apply_stimulus(OP_PUSH, 8'($urandom));
         else if (r < 60) apply_stimulus(OP_CLR, 8'h00);
         else if (r < 65) apply_stimulus(OP_BAD, 8'($urandom));
         else             apply_stimulus(OP_IDLE, 8'h00);
      end
      for (int i = 0; i < 600 && (exp_q.size() != 0 || !ready_drv); i++) apply_stimulus(OP_IDLE, 8'h00);
      check_output("random_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
